regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter_if.sv | 28 ++
 rtl/regfile_write_arbiter.sv | 79 +++++++
 tb/tb_regfile_write_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Bus bundle between the writeback pipeline, the multi-cycle unit and the register file write port.
// The arbiter connects through the slave modport; the driving environment uses master.
interface regfile_write_arbiter_if #(
    parameter int XLEN = 64
);
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            wb_stall;
    logic            md_valid;
    logic            md_ready;
    logic [4:0]      md_rd;
    logic [XLEN-1:0] md_data;
    logic            rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wdata;
    logic [1:0]      pend_cnt;

    modport master (
        output wb_valid, wb_rd, wb_data, md_valid, md_rd, md_data,
        input  wb_stall, md_ready, rf_we, rf_rd, rf_wdata, pend_cnt
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data, md_valid, md_rd, md_data,
        output wb_stall, md_ready, rf_we, rf_rd, rf_wdata, pend_cnt
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares one register file write port between pipeline writeback and a 2-deep queue of
// multi-cycle results; writeback has priority until a queued result starves for STARVE_LIMIT cycles.
module regfile_write_arbiter #(
    parameter int XLEN         = 64,
    parameter int STARVE_LIMIT = 4
) (
    input logic                 clk,
    input logic                 rst,
    regfile_write_arbiter_if.slave bus
);
    typedef enum logic {NORMAL, DRAIN} state_t;

    state_t          state, state_next;
    logic [4:0]      fifo_rd   [2];
    logic [XLEN-1:0] fifo_data [2];
    logic            rd_ptr, wr_ptr;
    logic [1:0]      count;
    logic [3:0]      age, age_next, age_inc;
    logic            wb_req, enq, deq;

    always_comb begin
        bus.md_ready = !rst && (count < 2'd2);
        bus.pend_cnt = rst ? 2'd0 : count;
        bus.wb_stall = !rst && (state == DRAIN);
        bus.rf_we    = 1'b0;
        bus.rf_rd    = 5'd0;
        bus.rf_wdata = '0;
        deq          = 1'b0;
        state_next   = NORMAL;
        wb_req       = bus.wb_valid && (bus.wb_rd != 5'd0);
        enq          = bus.md_valid && bus.md_ready && (bus.md_rd != 5'd0);
        age_inc      = age + 4'd1;

        if (!rst) begin
            if (state == NORMAL && wb_req) begin
                bus.rf_we    = 1'b1;
                bus.rf_rd    = bus.wb_rd;
                bus.rf_wdata = bus.wb_data;
            end else if (count != 2'd0) begin
                bus.rf_we    = 1'b1;
                bus.rf_rd    = fifo_rd[rd_ptr];
                bus.rf_wdata = fifo_data[rd_ptr];
                deq          = 1'b1;
            end
        end

        // Age counts cycles a queued head was passed over; hitting the limit forces one drain cycle.
        age_next = (deq || count == 2'd0) ? 4'd0 : age_inc;
        if (state == NORMAL && count != 2'd0 && !deq && age_inc == 4'(STARVE_LIMIT)) begin
            state_next = DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= NORMAL;
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            age    <= 4'd0;
        end else begin
            state <= state_next;
            age   <= age_next;
            if (enq) begin
                fifo_rd[wr_ptr]   <= bus.md_rd;
                fifo_data[wr_ptr] <= bus.md_data;
                wr_ptr            <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({enq, deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed scenarios followed by random traffic, each cycle compared against a queue-based
// reference model of the arbitration rules.
module tb_regfile_write_arbiter;
    localparam int XLEN         = 64;
    localparam int STARVE_LIMIT = 4;

    logic clk = 1'b0;
    logic rst;
    int   vectors    = 0;
    int   miscompares = 0;

    // Reference model: pending results in arrival order, starvation age, forced-drain flag.
    logic [4:0]      q_rd   [$];
    logic [XLEN-1:0] q_data [$];
    int              age    = 0;
    bit              drain  = 0;

    regfile_write_arbiter_if #(.XLEN(XLEN)) bus ();

    regfile_write_arbiter #(
        .XLEN(XLEN),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic wv, input logic [4:0] wr,
                                 input logic [XLEN-1:0] wd, input logic mv,
                                 input logic [4:0] mr, input logic [XLEN-1:0] md);
        logic            e_we, e_ready, e_stall, take_head, wb_req, enq;
        logic [4:0]      e_rd;
        logic [XLEN-1:0] e_data;
        int              size_before;

        @(negedge clk);
        rst          = r;
        bus.wb_valid = wv;
        bus.wb_rd    = wr;
        bus.wb_data  = wd;
        bus.md_valid = mv;
        bus.md_rd    = mr;
        bus.md_data  = md;
        #1;

        size_before = q_rd.size();
        wb_req      = wv && (wr != 5'd0);
        e_ready     = !r && (size_before < 2);
        e_stall     = !r && drain;
        take_head   = !r && (drain || !wb_req) && (size_before > 0);
        e_we        = 1'b0;
        e_rd        = 5'd0;
        e_data      = '0;
        if (!r && !drain && wb_req) begin
            e_we = 1'b1; e_rd = wr; e_data = wd;
        end else if (take_head) begin
            e_we = 1'b1; e_rd = q_rd[0]; e_data = q_data[0];
        end

        checkOutput("rf_we", XLEN'(bus.rf_we), XLEN'(e_we));
        checkOutput("wb_stall", XLEN'(bus.wb_stall), XLEN'(e_stall));
        checkOutput("md_ready", XLEN'(bus.md_ready), XLEN'(e_ready));
        checkOutput("pend_cnt", XLEN'(bus.pend_cnt), r ? '0 : XLEN'(size_before));
        if (e_we) begin
            checkOutput("rf_rd", XLEN'(bus.rf_rd), XLEN'(e_rd));
            checkOutput("rf_wdata", bus.rf_wdata, e_data);
        end

        if (r) begin
            q_rd.delete();
            q_data.delete();
            age   = 0;
            drain = 0;
        end else begin
            enq = mv && e_ready && (mr != 5'd0);
            if (take_head) begin
                void'(q_rd.pop_front());
                void'(q_data.pop_front());
            end
            if (enq) begin
                q_rd.push_back(mr);
                q_data.push_back(md);
            end
            age   = (take_head || size_before == 0) ? 0 : age + 1;
            drain = !drain && (age == STARVE_LIMIT);
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.wb_valid = 1'b0;
        bus.wb_rd    = '0;
        bus.wb_data  = '0;
        bus.md_valid = 1'b0;
        bus.md_rd    = '0;
        bus.md_data  = '0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        applyStimulus(0, 1, 5, 64'h1234, 0, 0, 0);

        applyStimulus(0, 0, 0, 0, 1, 7, 64'hAAAA);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Writeback held while one result starves until the forced drain cycle.
        applyStimulus(0, 0, 0, 0, 1, 7, 64'hBBBB);
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 3, 64'h33 + i, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        applyStimulus(0, 1, 3, 64'h44, 1, 8, 64'h88);
        applyStimulus(0, 1, 3, 64'h45, 1, 9, 64'h99);
        for (int i = 0; i < 12; i++) applyStimulus(0, 1, 3, 64'h50 + i, 1, 10, 64'hA0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        applyStimulus(0, 0, 0, 0, 1, 0, 64'hDEAD);
        applyStimulus(0, 1, 0, 64'hBEEF, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Reset lands exactly on the forced drain cycle with an entry queued.
        applyStimulus(0, 0, 0, 0, 1, 12, 64'hC0C0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 4, 64'h60 + i, 0, 0, 0);
        applyStimulus(1, 1, 4, 64'h70, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(99) < 2),
                          ($urandom_range(99) < 75),
                          5'($urandom_range(31)),
                          {32'($urandom), 32'($urandom)},
                          ($urandom_range(99) < 50),
                          5'($urandom_range(31)),
                          {32'($urandom), 32'($urandom)});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
